// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order word requests to
// instruction memory, buffers returned instructions with their PCs and hands them to decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [31:0]              imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_pc4,
  output logic [31:0]              id_instr,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic [CW+1:0] w_credits;
  logic          w_req_fire;
  logic          w_resp_drop;
  logic          w_resp_live;
  logic          w_resp_take;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_instr;

  // Every queue slot is reserved at request time, so a live response always finds room.
  assign w_credits      = {2'b00, r_count} + {2'b00, r_outstanding} + {2'b00, r_drop_cnt};
  assign imem_req_valid = !rst && !redirect_valid && (w_credits < (CW+2)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
  assign w_resp_live = imem_resp_valid && (r_drop_cnt == '0) && (r_outstanding != '0);
  assign w_resp_take = w_resp_drop || w_resp_live;
  assign w_push      = w_resp_live && !redirect_valid;
  assign w_pop       = id_valid && id_ready;

  assign w_head_pc    = r_pc_mem[r_rptr];
  assign w_head_instr = r_instr_mem[r_rptr];
  assign id_valid     = (r_count != '0);
  assign id_pc        = id_valid ? w_head_pc : 32'h0;
  assign id_pc4       = id_valid ? (w_head_pc + 32'd4) : 32'h0;
  assign id_instr     = id_valid ? w_head_instr : 32'h0;
  assign occupancy    = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else if (redirect_valid) begin
      // In-flight requests become stale; a response landing now is one of them.
      r_fetch_pc    <= redirect_pc;
      r_resp_pc     <= redirect_pc;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_drop_cnt    <= r_drop_cnt + r_outstanding - CW'(w_resp_take);
      r_outstanding <= '0;
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wptr    <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_resp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp_live);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_pc_mem[r_wptr]    <= r_resp_pc;
      r_instr_mem[r_wptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized bench for fetch_queue with a behavioural in-order,
// fixed-latency instruction memory and a sequential-PC reference for the decode stream.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_pc           (id_pc),
    .id_pc4          (id_pc4),
    .id_instr        (id_instr),
    .occupancy       (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  int          edgeCnt    = 0;
  int          memLat     = 1;
  logic        headActive = 1'b0;
  logic        injectResp = 1'b0;
  logic [31:0] injectData = 32'h0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory accepts on the edge and answers memLat cycles later, one response per cycle.
  always @(posedge clk) begin
    edgeCnt = edgeCnt + 1;
    if (rst) begin
      pend.delete();
    end else begin
      if (headActive) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, edgeCnt + memLat - 1});
    end
    #1;
    headActive      = (pend.size() > 0) && (pend[0].due <= edgeCnt);
    imem_resp_valid = injectResp || headActive;
    imem_resp_data  = injectResp ? injectData : (headActive ? memWord(pend[0].addr) : 32'h0);
  end

  task automatic applyStimulus(input logic rstIn, input logic rdy, input logic idr,
                               input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    rst            = rstIn;
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] expPc;
    logic [31:0] prevAddr;
    logic        prevStall;
    logic        redir;
    logic [31:0] rpc;
    int          pops;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] reset state");
    checkBit("rst_id_valid", id_valid, 1'b0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    checkBit("rst_req_valid", imem_req_valid, 1'b0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_id_pc4", id_pc4, 32'h0);
    checkOutput("rst_id_instr", id_instr, 32'h0);

    $display("[TB] streaming with 1-cycle memory");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkBit("t1_req_valid", imem_req_valid, 1'b1);
    checkOutput("t1_addr0", imem_req_addr, 32'h0);
    checkBit("t1_empty0", id_valid, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t1_addr1", imem_req_addr, 32'h4);
    checkBit("t1_empty1", id_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkBit("t1_id_valid", id_valid, 1'b1);
      checkOutput("t1_id_pc", id_pc, 32'(4 * i));
      checkOutput("t1_id_pc4", id_pc4, 32'(4 * i + 4));
      checkOutput("t1_id_instr", id_instr, memWord(32'(4 * i)));
      checkBit("t1_occ_le2", occupancy <= 3'd2, 1'b1);
    end

    $display("[TB] decode stall fills the queue");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t2_occ_full", 32'(occupancy), 32'd4);
    checkBit("t2_req_valid", imem_req_valid, 1'b0);
    checkOutput("t2_none_in_flight", 32'(pend.size()), 32'd0);
    checkOutput("t2_head", id_pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkBit("t2_drain_valid", id_valid, 1'b1);
      checkOutput("t2_drain_pc", id_pc, 32'(4 * i));
      checkOutput("t2_drain_instr", id_instr, memWord(32'(4 * i)));
    end

    $display("[TB] redirect with two stale requests in flight");
    memLat = 3;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    checkBit("t3_no_req_on_redirect", imem_req_valid, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkBit("t3_stale_dropped", id_valid, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkBit("t3_target_valid", id_valid, 1'b1);
    checkOutput("t3_target_pc", id_pc, 32'h100);
    checkOutput("t3_target_instr", id_instr, memWord(32'h100));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_target_next", id_pc, 32'h104);

    $display("[TB] redirect coinciding with response and pop");
    memLat = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_pc0", id_pc, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_pc4", id_pc, 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    checkBit("t4_pop_valid", id_valid, 1'b1);
    checkOutput("t4_pop_pc", id_pc, 32'h8);
    checkBit("t4_resp_present", imem_resp_valid, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkBit("t4_flushed", id_valid, 1'b0);
    checkOutput("t4_flushed_occ", 32'(occupancy), 32'd0);
    checkOutput("t4_new_addr", imem_req_addr, 32'h200);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkBit("t4_still_empty", id_valid, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_target_pc", id_pc, 32'h200);
    checkOutput("t4_target_instr", id_instr, memWord(32'h200));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_target_next", id_pc, 32'h204);

    $display("[TB] reset with entries queued and a response in flight");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("t6_occ_before", 32'(occupancy), 32'd3);
    injectData = 32'hDEAD_BEEF;
    injectResp = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    injectResp = 1'b0;
    checkBit("t6_id_valid", id_valid, 1'b0);
    checkOutput("t6_occ", 32'(occupancy), 32'd0);
    checkBit("t6_req_valid", imem_req_valid, 1'b1);
    checkOutput("t6_restart_addr", imem_req_addr, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkBit("t6_late_ignored", id_valid, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_first_pc", id_pc, 32'h0);
    checkOutput("t6_first_instr", id_instr, memWord(32'h0));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t6_second_pc", id_pc, 32'h4);

    $display("[TB] randomized traffic with redirects");
    memLat = 2;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    expPc     = 32'h0;
    prevStall = 1'b0;
    prevAddr  = 32'h0;
    pops      = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      redir = ((cyc % 100) == 50);
      rpc   = $urandom & 32'hFFFF_FFFC;
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), redir, rpc);
      checkBit("rnd_invariant", (32'(occupancy) + 32'(pend.size())) <= 32'(DEPTH), 1'b1);
      checkBit("rnd_req_valid", imem_req_valid,
               !redir && ((32'(occupancy) + 32'(pend.size())) < 32'(DEPTH)));
      if (prevStall && imem_req_valid) checkOutput("rnd_addr_stable", imem_req_addr, prevAddr);
      if (id_valid && id_ready) begin
        checkOutput("rnd_stream_pc", id_pc, expPc);
        checkOutput("rnd_stream_pc4", id_pc4, expPc + 32'd4);
        checkOutput("rnd_stream_instr", id_instr, memWord(expPc));
        expPc = expPc + 32'd4;
        pops++;
      end
      if (redir) expPc = rpc;
      prevStall = imem_req_valid && !imem_req_ready;
      prevAddr  = imem_req_addr;
    end
    checkBit("rnd_progress", pops > 200, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
